gp_resolve: RTL and testbench
=============================

GP_RESOLVE -- requirements
Module: gp_resolve

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port `in_valid`: input, 1 bit, G/P operand presented.
REQ-005 SHALL have port `in_ready`: output, 1 bit, block can accept an operand.
REQ-006 SHALL have port `g_in`: input, 32 bits, per-bit generate (a AND b).
REQ-007 SHALL have port `p_in`: input, 32 bits, per-bit propagate (a XOR b).
REQ-008 SHALL have port `cin`: input, 1 bit, carry-in.
REQ-009 SHALL have port `out_valid`: output, 1 bit, result available.
REQ-010 SHALL have port `out_ready`: input, 1 bit, consumer takes the result.
REQ-011 SHALL have port `sum`: output, 32 bits, resolved sum.
REQ-012 SHALL have port `cout`: output, 1 bit, carry out of bit 31.
REQ-013 SHALL have port `ovf`: output, 1 bit, signed overflow; present only under OVF_FLAG_EN.

Function
REQ-014 SHALL use FSM states IDLE, RESOLVE and DONE; `in_ready` is 1 only in IDLE and is decoded from state alone.
REQ-015 SHALL accept an operand when `in_valid` and `in_ready` are both 1; it SHALL latch `p_in` unmodified and initialise G[i]=g_in[i], P[i]=p_in[i], with cin folded in as G[0]=g_in[0] | (p_in[0] & cin); the state then goes to RESOLVE with level=0.
REQ-016 SHALL perform one Knowles/Kogge-Stone prefix level per RESOLVE cycle, with d=2^level:
- for i>=d: G[i] <= G[i] | (P[i] & G[i-d]) and P[i] <= P[i] & P[i-d];
- for i<d: G[i] and P[i] are unchanged.
REQ-017 SHALL run the level counter 0..4 (3 bits); after level 4 completes, the state goes to DONE.
REQ-018 SHALL register outputs on entry to DONE:
- sum[0] = p[0] ^ cin;
- sum[i] = p[i] ^ G[i-1] for i=1..31;
- cout = G[31].
REQ-019 SHALL have fixed latency: accept in cycle N gives `out_valid`=1 in cycle N+6; throughput is at most one operand per 7 cycles (no overlap).
REQ-020 SHALL hold `out_valid`, `sum`, `cout` (and `ovf`) stable in DONE until `out_ready`=1; the DONE-to-IDLE transition occurs on the cycle `out_valid` & `out_ready`.
REQ-021 SHALL drop `out_valid` to 0 the cycle after the handshake; `sum`/`cout` retain their last value.
REQ-022 SHALL ignore `in_valid` outside IDLE and SHALL NOT latch any operand there.
REQ-023 SHALL treat `out_ready` asserted before `out_valid` as no effect.

Reset
REQ-024 SHALL, on `rst`=1 at a rising edge, set state=IDLE, level=0, out_valid=0, sum=0, cout=0, ovf=0, and clear the G/P registers to 0.
REQ-025 SHALL, on reset during RESOLVE or DONE, abort the operation; no result is ever presented for it, and `in_ready`=1 on the first cycle after `rst` deasserts.

Configuration
REQ-026 SHALL, with OVF_FLAG_EN defined, provide port `ovf` registered on DONE entry as ovf = cout ^ G[30] (carry into bit 31 XOR carry out).
REQ-027 SHALL, without OVF_FLAG_EN, have no `ovf` port and no associated logic; all other behaviour is identical.

Structure
REQ-028 SHALL place WIDTH=32, LEVELS=5, the FSM state encoding type and level counter width in shared package `alu32_pkg`.
REQ-029 SHALL instantiate sub-module `prefix_cell` (inputs gi, pi, gj, pj; outputs go=gi|(pi&gj), po=pi&pj) once per bit position in a generate loop, with the partner index selected by the current level.

Verification (bench derives g_in=a&b, p_in=a^b)
REQ-030 SHALL cover: a=0x12345678, b=0x9ABCDEF0, cin=0 -> sum=0xACF13568, cout=0, ovf=0.
REQ-031 SHALL cover: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-032 SHALL cover: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1 (OVF_FLAG_EN build).
REQ-033 SHALL cover: accept in cycle N -> out_valid first high in cycle N+6; in_ready=0 in cycles N+1..N+6.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> sum/cout/out_valid stable, in_ready=0; on out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: rst pulsed during RESOLVE level 2 -> next cycle out_valid=0, sum=0, in_ready=1; no result is presented for the aborted operand.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared types and constants for the 32-bit generate/propagate carry resolver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu32_pkg;

    localparam int WIDTH  = 32;
    localparam int LEVELS = 5;
    localparam int LVL_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [LVL_W-1:0] level_t;

    localparam level_t LAST_LEVEL = level_t'(LEVELS - 1);

    // Fold the carry-in into bit 0's generate so the prefix tree sees it as a
    // plain carry source and G[i] becomes the carry out of bit i.
    function automatic logic [WIDTH-1:0] fold_cin(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             c
    );
        return g | {{(WIDTH-1){1'b0}}, p[0] & c};
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// Single Kogge-Stone prefix operator: combines a bit's (G,P) with its partner's.
// Latency: combinational.
// Backpressure: none.
module prefix_cell (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    input  logic pj,
    output logic go,
    output logic po
);

    assign go = gi | (pi & gj);
    assign po = pi & pj;

endmodule

// File: rtl/gp_resolve.sv
// Resolves per-bit generate/propagate into a 32-bit sum with a 5-level iterative Kogge-Stone tree.
// Latency: operand accepted in cycle N gives out_valid in cycle N+6; one operand per 7 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. OVF_FLAG_EN adds the ovf port.
module gp_resolve
    import alu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] g_in,
    input  logic [31:0] p_in,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout
`ifdef OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    state_t             state_q, state_d;
    level_t             level_q, level_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   praw_q, praw_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef OVF_FLAG_EN
    logic               ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0]   g_nxt;
    logic [WIDTH-1:0]   p_nxt;
    logic               accept;
    logic               last_level;

    // One prefix cell per bit; the partner at distance 2^level is picked by the
    // current level. Bits with no partner see (G=0,P=1), which is the identity.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [(2**LVL_W)-1:0] cand_g;
        logic [(2**LVL_W)-1:0] cand_p;

        for (genvar l = 0; l < 2**LVL_W; l++) begin : g_lvl
            if (l < LEVELS && i >= (1 << l)) begin : g_pair
                assign cand_g[l] = g_q[i - (1 << l)];
                assign cand_p[l] = p_q[i - (1 << l)];
            end else begin : g_pass
                assign cand_g[l] = 1'b0;
                assign cand_p[l] = 1'b1;
            end
        end

        prefix_cell u_cell (
            .gi (g_q[i]),
            .pi (p_q[i]),
            .gj (cand_g[level_q]),
            .pj (cand_p[level_q]),
            .go (g_nxt[i]),
            .po (p_nxt[i])
        );
    end

    assign accept     = in_valid & in_ready;
    assign last_level = (level_q == LAST_LEVEL);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, five resolve steps, hold DONE until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)              state_d = RESOLVE;
            RESOLVE: if (last_level)          state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: load operand, step the tree, capture result on the last level.
    always_comb begin
        level_d = level_q;
        g_d     = g_q;
        p_d     = p_q;
        praw_d  = praw_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d     = fold_cin(g_in, p_in, cin);
                    p_d     = p_in;
                    praw_d  = p_in;
                    cin_d   = cin;
                    level_d = '0;
                end
            end
            RESOLVE: begin
                g_d = g_nxt;
                p_d = p_nxt;
                if (last_level) begin
                    level_d = '0;
                    // g_nxt is the fully resolved carry vector at this point.
                    sum_d   = {praw_q[WIDTH-1:1] ^ g_nxt[WIDTH-2:0], praw_q[0] ^ cin_q};
                    cout_d  = g_nxt[WIDTH-1];
`ifdef OVF_FLAG_EN
                    ovf_d   = g_nxt[WIDTH-1] ^ g_nxt[WIDTH-2];
`endif
                end else begin
                    level_d = level_q + level_t'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset wipes any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            g_q     <= '0;
            p_q     <= '0;
            praw_q  <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            level_q <= level_d;
            g_q     <= g_d;
            p_q     <= p_d;
            praw_q  <= praw_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef OVF_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_gp_resolve.sv
// Directed bench for gp_resolve: sums, carry/overflow, latency, stall and mid-operation reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Build with OVF_FLAG_EN to also check the overflow flag.
module tb_gp_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] g_in;
    logic [31:0] p_in;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef OVF_FLAG_EN
    logic        ovf;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gp_resolve dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .p_in      (p_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one operand, measure latency, check the result, optionally stall, then consume.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] es, input logic ec, input logic eo,
                          input int stall, input bit early, input bit junk);
        int lat;
        chk({nm, ".rdy_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        g_in     = a & b;
        p_in     = a ^ b;
        cin      = ci;
        tick();
        lat = 1;
        if (junk) begin
            g_in = 32'hFFFF0000;
            p_in = 32'h0000FFFF;
            cin  = ~ci;
        end else begin
            in_valid = 1'b0;
        end
        if (early) out_ready = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk({nm, ".rdy_busy"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'd6);
        chk({nm, ".rdy_done"}, 32'(in_ready), 32'd0);
        chk({nm, ".sum"}, sum, es);
        chk({nm, ".cout"}, 32'(cout), 32'(ec));
`ifdef OVF_FLAG_EN
        chk({nm, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: undefined ovf expectation for %s", nm);
`endif
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({nm, ".stall_vld"}, 32'(out_valid), 32'd1);
            chk({nm, ".stall_sum"}, sum, es);
            chk({nm, ".stall_cout"}, 32'(cout), 32'(ec));
            chk({nm, ".stall_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, ".vld_drop"}, 32'(out_valid), 32'd0);
        chk({nm, ".rdy_back"}, 32'(in_ready), 32'd1);
        chk({nm, ".sum_keep"}, sum, es);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        g_in      = '0;
        p_in      = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd1);
        chk("rst.sum", sum, 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
`ifdef OVF_FLAG_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif

        //      name     a             b             cin   sum           cout  ovf   stall early junk
        run_op("v_mix",  32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 0,  1'b0, 1'b0);
        run_op("v_ones", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0,  1'b0, 1'b0);
        run_op("v_povf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0,  1'b0, 1'b0);
        run_op("v_novf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0,  1'b0, 1'b1);
        run_op("v_alt",  32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0, 0,  1'b1, 1'b0);
        run_op("v_cin",  32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 0,  1'b0, 1'b0);
        run_op("v_stal", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 10, 1'b0, 1'b0);

        // Abort an operand at resolve level 2 with a reset pulse.
        in_valid = 1'b1;
        g_in     = 32'h12345678 & 32'h9ABCDEF0;
        p_in     = 32'h12345678 ^ 32'h9ABCDEF0;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.vld", 32'(out_valid), 32'd0);
        chk("abort.sum", sum, 32'd0);
        chk("abort.cout", 32'(cout), 32'd0);
        chk("abort.rdy", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort.no_result", 32'(seen), 32'd0);

        run_op("v_post", 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
